// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network output path.
//   - scc_state_t : classifier FSM states (IDLE / COUNT / SCAN / DONE)
//   - lif_state_t : state encodings of the upstream time-multiplexed LIF engine
//   - DEF_*       : default classifier dimensions
//   - width_of()  : clog2-based width helper (never returns less than 1)
package snn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } scc_state_t;

  typedef enum logic [1:0] {
    LIF_IDLE  = 2'd0,
    LIF_LOAD  = 2'd1,
    LIF_INTEG = 2'd2,
    LIF_FIRE  = 2'd3
  } lif_state_t;

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_N_CLASS = 10;
  localparam int DEF_N_STEPS = 25;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_CIDX_W  = width_of(DEF_N_CLASS);
  localparam int DEF_STEP_W  = 8;

endpackage

// File: rtl/scc_sat_counter.sv
// Saturating up-counter for one class of the spike-count classifier.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous reset, active low
//   clear  in  synchronous clear to 0 (has priority over inc_en)
//   inc_en in  add one this cycle, sticking at all-ones instead of wrapping
//   count  out current count
module scc_sat_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc_en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/spike_count_classifier.sv
// Output stage after the LIF layer engine: accumulates per-class spike counts
// over a frame of N_STEPS timesteps, then runs a one-class-per-cycle argmax
// scan and pulses class_valid with the winner.
// Optional feature macro: SCC_MARGIN_EN adds runner-up tracking and the
// class_margin output (winner count minus runner-up count).
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   frame_start      pulse: clear counts and begin a new frame (any state)
//   step_done        pulse: spikes_in_bits valid this cycle
//   spikes_in_bits   spikes of one timestep, bit i = class i
//   busy             high while counting or scanning
//   class_valid      1-cycle pulse when a decision is ready
//   class_idx        winning class, held until next frame_start
//   class_count      spike count of the winner, held
//   no_spikes        winner count is zero, held
//   class_margin     [SCC_MARGIN_EN] winner minus runner-up count, held
module spike_count_classifier
  import snn_pkg::*;
#(
  parameter int N_CLASS = DEF_N_CLASS,
  parameter int N_STEPS = DEF_N_STEPS,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CIDX_W  = DEF_CIDX_W,
  parameter int STEP_W  = DEF_STEP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               step_done,
  input  logic [N_CLASS-1:0] spikes_in_bits,
  output logic               busy,
  output logic               class_valid,
  output logic [CIDX_W-1:0]  class_idx,
  output logic [CNT_W-1:0]   class_count,
  output logic               no_spikes
`ifdef SCC_MARGIN_EN
  ,
  output logic [CNT_W-1:0]   class_margin
`endif
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);
  localparam logic [CIDX_W-1:0] SCAN_LAST = CIDX_W'(N_CLASS - 1);

  scc_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt [N_CLASS];
  logic [STEP_W-1:0] step_idx;
  logic [CIDX_W-1:0] scan_idx, best_idx, best_idx_nxt;
  logic [CNT_W-1:0]  scan_cnt, best_cnt, best_cnt_nxt;
  logic              step_take, last_step, scan_last, new_best;

  // A step only counts while in COUNT and when frame_start is not
  // simultaneously restarting the frame.
  assign step_take = (state == S_COUNT) && step_done && !frame_start;
  assign last_step = step_take && (step_idx == STEP_LAST);
  assign scan_last = (state == S_SCAN) && (scan_idx == SCAN_LAST);
  assign busy      = (state == S_COUNT) || (state == S_SCAN);

  for (genvar i = 0; i < N_CLASS; i++) begin : g_cnt
    scc_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (frame_start),
      .inc_en (step_take && spikes_in_bits[i]),
      .count  (cnt[i])
    );
  end

  // Select the count under inspection; a single comparator then walks the
  // classes one per cycle. Strict greater-than keeps the lowest index on ties.
  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < N_CLASS; i++) begin
      if (scan_idx == CIDX_W'(i)) scan_cnt = cnt[i];
    end
    new_best     = scan_cnt > best_cnt;
    best_cnt_nxt = new_best ? scan_cnt : best_cnt;
    best_idx_nxt = new_best ? scan_idx : best_idx;
  end

`ifdef SCC_MARGIN_EN
  logic [CNT_W-1:0] second_cnt, second_cnt_nxt;

  // The displaced best becomes the runner-up; otherwise a count that beats
  // the current runner-up replaces it. Equal top counts leave margin 0.
  always_comb begin
    second_cnt_nxt = second_cnt;
    if (new_best)                     second_cnt_nxt = best_cnt;
    else if (scan_cnt > second_cnt)   second_cnt_nxt = scan_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_cnt   <= '0;
      class_margin <= '0;
    end else if (frame_start) begin
      class_margin <= '0;
    end else begin
      if (last_step)          second_cnt   <= '0;
      if (state == S_SCAN)    second_cnt   <= second_cnt_nxt;
      if (scan_last)          class_margin <= best_cnt_nxt - second_cnt_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // DONE behaves like IDLE; frame_start restarts counting from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_COUNT: if (last_step) state_nxt = S_SCAN;
      S_SCAN:  if (scan_last) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
    if (frame_start) state_nxt = S_COUNT;
  end

  // Step counter, argmax registers and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_idx    <= '0;
      scan_idx    <= '0;
      best_cnt    <= '0;
      best_idx    <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_count <= '0;
      no_spikes   <= 1'b0;
    end else if (frame_start) begin
      step_idx    <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_count <= '0;
      no_spikes   <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      if (step_take) step_idx <= step_idx + STEP_W'(1);
      if (last_step) begin
        scan_idx <= '0;
        best_cnt <= '0;
        best_idx <= '0;
      end
      if (state == S_SCAN) begin
        scan_idx <= scan_idx + CIDX_W'(1);
        best_cnt <= best_cnt_nxt;
        best_idx <= best_idx_nxt;
        if (scan_last) begin
          class_valid <= 1'b1;
          class_idx   <= best_idx_nxt;
          class_count <= best_cnt_nxt;
          no_spikes   <= (best_cnt_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Self-checking bench for spike_count_classifier.
// Instance u_dut: N_CLASS=10, N_STEPS=4, CNT_W=8.
// Instance u_sat: N_CLASS=4, N_STEPS=6, CNT_W=2 (saturation case).
// Define SCC_MARGIN_EN when compiling to also exercise class_margin.
module tb_spike_count_classifier;

  localparam int NC  = 10;
  localparam int NS  = 4;
  localparam int CMX = 255;

  logic          clk;
  logic          rst_n;
  logic          frame_start, step_done;
  logic [NC-1:0] spikes;
  logic          busy, class_valid, no_spikes;
  logic [3:0]    class_idx;
  logic [7:0]    class_count;

  logic          fs_b, sd_b;
  logic [3:0]    sp_b;
  logic          busy_b, valid_b, nosp_b;
  logic [1:0]    idx_b, cnt_b;

`ifdef SCC_MARGIN_EN
  logic [7:0]    class_margin;
  logic [1:0]    margin_b;
`endif

  int total = 0;
  int bad   = 0;
  int mcnt[NC];

  spike_count_classifier #(
    .N_CLASS(NC), .N_STEPS(NS), .CNT_W(8), .CIDX_W(4), .STEP_W(8)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .step_done      (step_done),
    .spikes_in_bits (spikes),
    .busy           (busy),
    .class_valid    (class_valid),
    .class_idx      (class_idx),
    .class_count    (class_count),
    .no_spikes      (no_spikes)
`ifdef SCC_MARGIN_EN
    ,
    .class_margin   (class_margin)
`endif
  );

  spike_count_classifier #(
    .N_CLASS(4), .N_STEPS(6), .CNT_W(2), .CIDX_W(2), .STEP_W(3)
  ) u_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (fs_b),
    .step_done      (sd_b),
    .spikes_in_bits (sp_b),
    .busy           (busy_b),
    .class_valid    (valid_b),
    .class_idx      (idx_b),
    .class_count    (cnt_b),
    .no_spikes      (nosp_b)
`ifdef SCC_MARGIN_EN
    ,
    .class_margin   (margin_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("[TB] %s check did not hold", tag);
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < NC; i++) mcnt[i] = 0;
  endtask

  task automatic do_step(input logic [NC-1:0] sp);
    @(negedge clk);
    step_done = 1'b1;
    spikes    = sp;
    @(negedge clk);
    step_done = 1'b0;
    spikes    = '0;
    for (int i = 0; i < NC; i++)
      if (sp[i]) mcnt[i] = (mcnt[i] + 1 > CMX) ? CMX : mcnt[i] + 1;
  endtask

  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (class_valid === 1'b1) seen++;
    end
  endtask

  // Winner = largest count, lowest index among equals; margin = largest
  // minus second largest of the whole multiset of counts.
  task automatic model_decide(output int idx, output int cnt, output int marg);
    int q[$];
    int mx;
    mx = 0;
    for (int i = 0; i < NC; i++) if (mcnt[i] > mx) mx = mcnt[i];
    idx = -1;
    for (int i = 0; i < NC; i++) if (idx < 0 && mcnt[i] == mx) idx = i;
    for (int i = 0; i < NC; i++) q.push_back(mcnt[i]);
    q.rsort();
    cnt  = mx;
    marg = q[0] - q[1];
  endtask

  // Called right after the final step; class_valid is due NC+1 cycles after
  // the step_done cycle, i.e. NC negedges after the one ending the step.
  task automatic expect_decision(input string tag);
    int lat, eidx, ecnt, emarg;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (class_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    model_decide(eidx, ecnt, emarg);
    check({tag, "_latency"}, 32'(lat), 32'(NC));
    check({tag, "_idx"}, 32'(class_idx), 32'(eidx));
    check({tag, "_count"}, 32'(class_count), 32'(ecnt));
    check({tag, "_nospk"}, 32'(no_spikes), 32'(ecnt == 0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
`ifdef SCC_MARGIN_EN
    check({tag, "_margin"}, 32'(class_margin), 32'(emarg));
`endif
    @(negedge clk);
    check({tag, "_pulse"}, 32'(class_valid), 32'(0));
  endtask

  initial begin
    int seen, lat;
    rst_n = 1'b0; frame_start = 1'b0; step_done = 1'b0; spikes = '0;
    fs_b = 1'b0; sd_b = 1'b0; sp_b = '0;
    for (int i = 0; i < NC; i++) mcnt[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_valid", 32'(class_valid), 32'(0));
    check("rst_idx", 32'(class_idx), 32'(0));
    check("rst_count", 32'(class_count), 32'(0));
    check("rst_nospk", 32'(no_spikes), 32'(0));
    rst_n = 1'b1;

    // T1: async reset mid-COUNT, then steps ignored until frame_start
    frame_begin();
    do_step(10'h3FF);
    check("t1_busy_count", 32'(busy), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_async_busy", 32'(busy), 32'(0));
    check("t1_async_count", 32'(class_count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < NS; s++) do_step(10'h3FF);
    count_valid(20, seen);
    check("t1_ignored_valid", 32'(seen), 32'(0));
    check("t1_ignored_busy", 32'(busy), 32'(0));

    // T2: class 3 every step, class 7 on two steps
    frame_begin();
    do_step(10'h088); do_step(10'h088); do_step(10'h008); do_step(10'h008);
    expect_decision("t2");
    check("t2_const_idx", 32'(class_idx), 32'(3));
    check("t2_const_count", 32'(class_count), 32'(4));
    repeat (3) @(negedge clk);
    check("t2_held_idx", 32'(class_idx), 32'(3));

    // T3: classes 2 and 5 tie at 3
    frame_begin();
    do_step(10'h024); do_step(10'h024); do_step(10'h024); do_step(10'h001);
    expect_decision("t3");
    check("t3_const_idx", 32'(class_idx), 32'(2));

    // T4: silent frame
    frame_begin();
    for (int s = 0; s < NS; s++) do_step('0);
    expect_decision("t4");
    check("t4_const_nospk", 32'(no_spikes), 32'(1));
    count_valid(5, seen);
    check("t4_single_pulse", 32'(seen), 32'(0));

    // Random frames against the model
    for (int f = 0; f < 6; f++) begin
      frame_begin();
      for (int s = 0; s < NS; s++) do_step(NC'($urandom_range(0, 1023)));
      expect_decision($sformatf("rnd%0d", f));
    end

    // T6a: frame_start during SCAN aborts and clears
    frame_begin();
    for (int s = 0; s < NS; s++) do_step(10'h008);
    expect_decision("t6_pre");
    frame_begin();
    for (int s = 0; s < NS; s++) do_step(10'h208);
    repeat (3) @(negedge clk);
    check("t6_scan_busy", 32'(busy), 32'(1));
    frame_begin();
    check("t6_cleared_idx", 32'(class_idx), 32'(0));
    check("t6_cleared_count", 32'(class_count), 32'(0));
    count_valid(15, seen);
    check("t6_abort_novalid", 32'(seen), 32'(0));
    do_step(10'h040); do_step('0); do_step('0); do_step('0);
    expect_decision("t6_after");
    check("t6_const_idx", 32'(class_idx), 32'(6));

    // T6b: frame_start together with step_done discards that step
    frame_begin();
    @(negedge clk);
    frame_start = 1'b1; step_done = 1'b1; spikes = 10'h3FF;
    @(negedge clk);
    frame_start = 1'b0; step_done = 1'b0; spikes = '0;
    for (int i = 0; i < NC; i++) mcnt[i] = 0;
    for (int s = 0; s < NS - 1; s++) do_step(10'h100);
    count_valid(15, seen);
    check("t6_coll_novalid", 32'(seen), 32'(0));
    do_step(10'h100);
    expect_decision("t6_coll");
    check("t6_coll_count", 32'(class_count), 32'(4));

    // T5: saturation on the 2-bit instance
    @(negedge clk); fs_b = 1'b1;
    @(negedge clk); fs_b = 1'b0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      sd_b = 1'b1;
      sp_b = (s < 2) ? 4'b0110 : 4'b0010;
      @(negedge clk);
      sd_b = 1'b0;
      sp_b = '0;
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid_b === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("t5_latency", 32'(lat), 32'(4));
    check("t5_idx", 32'(idx_b), 32'(1));
    check("t5_count", 32'(cnt_b), 32'(3));
    check("t5_nospk", 32'(nosp_b), 32'(0));
`ifdef SCC_MARGIN_EN
    check("t5_margin", 32'(margin_b), 32'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
